// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared constants and state encoding for the data cache controller
//
// Index field is addr[INDEX_MSB:INDEX_LSB]; the stored label is addr[31:TAG_LSB].
package dcache_pkg;

  localparam int INDEX_MSB = 6;
  localparam int INDEX_LSB = 2;
  localparam int TAG_LSB   = 7;
  localparam int LABEL_W   = 25;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WTHRU = 2'd2
  } dc_state_e;

endpackage

// File: rtl/dcache_wbuf.sv
// rtl/dcache_wbuf.sv - one-entry store buffer that drains through the memory port
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   push                 capture push_addr/push_data (wins over a same-cycle drain_ack)
//   drain_ack            memory accepted the buffered write; entry frees
//   drain_req            entry valid, i.e. a write is pending toward memory
//   drain_addr/data      the buffered write
module dcache_wbuf
  import dcache_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              drain_ack,
  output logic              drain_req,
  output logic [ADDR_W-1:0] drain_addr,
  output logic [DATA_W-1:0] drain_data
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else if (push) begin
      // A push in the drain-ack cycle refills the entry immediately.
      valid_q <= 1'b1;
      addr_q  <= push_addr;
      data_q  <= push_data;
    end else if (drain_ack) begin
      valid_q <= 1'b0;
    end
  end

  assign drain_req  = valid_q;
  assign drain_addr = addr_q;
  assign drain_data = data_q;

endmodule

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller (MEM stage)
//
// Optional feature macro: DCACHE_WBUF_EN (one-entry write buffer, stores retire without stalling).
//
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata          MEM-stage access, held stable while cpu_stall is high
//   cpu_rdata, cpu_stall           load result (0 when no load completes), pipeline freeze
//   cache_addr/wen/wdata           array address (= cpu_addr), one-cycle write strobe, write word
//   cache_valid/label/rdata        contents of the indexed line
//   mem_req/we/addr/wdata          memory request, stable until mem_ack
//   mem_ack, mem_rdata             one-cycle completion pulse, read data in that cycle
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TAG_LSB = 7
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [DATA_W-1:0]         cpu_wdata,
  output logic [DATA_W-1:0]         cpu_rdata,
  output logic                      cpu_stall,
  output logic [ADDR_W-1:0]         cache_addr,
  output logic                      cache_wen,
  output logic [DATA_W-1:0]         cache_wdata,
  input  logic                      cache_valid,
  input  logic [ADDR_W-TAG_LSB-1:0] cache_label,
  input  logic [DATA_W-1:0]         cache_rdata,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] FILL  = ST_FILL;
  localparam logic [1:0] WTHRU = ST_WTHRU;

  logic [1:0]        state, state_nxt;
  logic              hit;
  logic [ADDR_W-1:0] addr_al;
  logic              issue_fill, issue_store, req_done;

  // Registered request for fills (and write-through stores when no buffer).
  logic              req_q, we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign hit        = cache_valid && (cache_label == cpu_addr[ADDR_W-1:TAG_LSB]);
  assign addr_al    = {cpu_addr[ADDR_W-1:2], 2'b00};
  assign cache_addr = cpu_addr;

`ifdef DCACHE_WBUF_EN
  logic              wb_valid, wb_push, wb_ack, wb_free;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  // The buffer is always empty while a fill is outstanding, so any ack seen
  // with the buffer valid belongs to the drain.
  assign wb_ack  = wb_valid && mem_ack;
  assign wb_free = !wb_valid || wb_ack;

  dcache_wbuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .resetn     (resetn),
    .push       (wb_push),
    .push_addr  (addr_al),
    .push_data  (cpu_wdata),
    .drain_ack  (wb_ack),
    .drain_req  (wb_valid),
    .drain_addr (wb_addr),
    .drain_data (wb_data)
  );

  // Drain owns the port whenever the buffer holds an entry.
  assign mem_req   = wb_valid | req_q;
  assign mem_we    = wb_valid ? 1'b1    : we_q;
  assign mem_addr  = wb_valid ? wb_addr : addr_q;
  assign mem_wdata = wb_valid ? wb_data : wdata_q;
`else
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
`endif

  always_comb begin
    state_nxt   = state;
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    cache_wen   = 1'b0;
    cache_wdata = '0;
    issue_fill  = 1'b0;
    issue_store = 1'b0;
    req_done    = 1'b0;
`ifdef DCACHE_WBUF_EN
    wb_push     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (!cpu_we) begin
            if (hit) begin
              cpu_rdata = cache_rdata;
            end else begin
              cpu_stall = 1'b1;
`ifdef DCACHE_WBUF_EN
              // Pending write must reach memory before the fill is issued.
              issue_fill = wb_free;
`else
              issue_fill = 1'b1;
`endif
              if (issue_fill) state_nxt = FILL;
            end
          end else begin
`ifdef DCACHE_WBUF_EN
            if (wb_free) begin
              wb_push     = 1'b1;
              cache_wen   = 1'b1;
              cache_wdata = cpu_wdata;
            end else begin
              cpu_stall = 1'b1;
            end
`else
            cpu_stall   = 1'b1;
            issue_store = 1'b1;
            state_nxt   = WTHRU;
`endif
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          cache_wen   = 1'b1;
          cache_wdata = mem_rdata;
          cpu_rdata   = mem_rdata;
          req_done    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      WTHRU: begin
        // Array is updated only once memory has accepted the write.
        if (mem_ack) begin
          cache_wen   = 1'b1;
          cache_wdata = cpu_wdata;
          req_done    = 1'b1;
          state_nxt   = IDLE;
        end else begin
          cpu_stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (issue_fill) begin
        req_q  <= 1'b1;
        we_q   <= 1'b0;
        addr_q <= addr_al;
      end else if (issue_store) begin
        req_q   <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= addr_al;
        wdata_q <= cpu_wdata;
      end else if (req_done) begin
        req_q <= 1'b0;
      end
    end
  end

endmodule
